// File: rtl/mult_div_unit.sv
// Multicycle multiply/divide unit owning the HI/LO register pair.
// Results are computed from operands latched at acceptance and are
// committed to HI/LO on the same edge that drops Busy.
module mult_div_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [2:0]  MDOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic [31:0]        hi_q, hi_d;
    logic [31:0]        lo_q, lo_d;
    logic [31:0]        a_q, a_d;
    logic [31:0]        b_q, b_d;
    logic [1:0]         op_q, op_d;

    logic [63:0]        prod_s;
    logic [63:0]        prod_u;
    logic               div_signed;
    logic               a_neg;
    logic               b_neg;
    logic [31:0]        a_mag;
    logic [31:0]        b_mag;
    logic [31:0]        quo_mag;
    logic [31:0]        rem_mag;
    logic [31:0]        quo;
    logic [31:0]        rem;

    // Arithmetic on the latched operands; division done in sign-magnitude so
    // that 0x80000000 / -1 wraps to 0x80000000 without special casing.
    always_comb begin
        prod_s     = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
        prod_u     = {32'd0, a_q} * {32'd0, b_q};
        div_signed = (op_q == 2'b10);
        a_neg      = div_signed && a_q[31];
        b_neg      = div_signed && b_q[31];
        a_mag      = a_neg ? (32'd0 - a_q) : a_q;
        b_mag      = b_neg ? (32'd0 - b_q) : b_q;
        quo_mag    = 32'd0;
        rem_mag    = 32'd0;
        if (b_mag != 32'd0) begin
            quo_mag = a_mag / b_mag;
            rem_mag = a_mag % b_mag;
        end
        quo = (a_neg ^ b_neg) ? (32'd0 - quo_mag) : quo_mag;
        rem = a_neg ? (32'd0 - rem_mag) : rem_mag;
    end

    // Next-state: accept in IDLE, count down in RUN, commit result on the last cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        unique case (state_q)
            IDLE: begin
                if (Start) begin
                    case (MDOp)
                        3'b000, 3'b001: begin
                            state_d = RUN;
                            cnt_d   = CNT_W'(MULT_CYCLES);
                            busy_d  = 1'b1;
                            a_d     = A;
                            b_d     = B;
                            op_d    = MDOp[1:0];
                        end
                        3'b010, 3'b011: begin
                            state_d = RUN;
                            cnt_d   = CNT_W'(DIV_CYCLES);
                            busy_d  = 1'b1;
                            a_d     = A;
                            b_d     = B;
                            op_d    = MDOp[1:0];
                        end
                        3'b100:  hi_d = A;
                        3'b101:  lo_d = A;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    case (op_q)
                        2'b00: {hi_d, lo_d} = prod_s;
                        2'b01: {hi_d, lo_d} = prod_u;
                        default: begin
                            // A zero divisor leaves HI/LO untouched.
                            if (b_q != 32'd0) begin
                                hi_d = rem;
                                lo_d = quo;
                            end
                        end
                    endcase
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and result registers with synchronous reset taking priority.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            op_q    <= 2'b00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
        end
    end

    assign Busy = busy_q;
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit against a plain-arithmetic HI/LO model.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        Start;
    logic [2:0]  MDOp;
    logic [31:0] A;
    logic [31:0] B;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;

    mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .Start (Start),
        .MDOp  (MDOp),
        .A     (A),
        .B     (B),
        .Busy  (Busy),
        .HI    (HI),
        .LO    (LO)
    );

    always #5 clk = ~clk;

    // Expected Busy length for an operation.
    function automatic int exp_cycles(input logic [2:0] op);
        case (op)
            3'd0, 3'd1: return 5;
            3'd2, 3'd3: return 10;
            default:    return 0;
        endcase
    endfunction

    // Reference model: 64-bit integer arithmetic on the operands.
    task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          sa;
        longint          sb;
        longint unsigned ua;
        longint unsigned ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = 64'(a);
        ub = 64'(b);
        case (op)
            3'd0: {exp_hi, exp_lo} = 64'(sa * sb);
            3'd1: {exp_hi, exp_lo} = ua * ub;
            3'd2: if (b != 32'd0) begin
                exp_lo = 32'(sa / sb);
                exp_hi = 32'(sa % sb);
            end
            3'd3: if (b != 32'd0) begin
                exp_lo = a / b;
                exp_hi = a % b;
            end
            3'd4: exp_hi = a;
            3'd5: exp_lo = a;
            default: ;
        endcase
    endtask

    // Present a one-cycle request at the current negedge; scramble operands afterwards.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        Start = 1'b1;
        MDOp  = op;
        A     = a;
        B     = b;
        @(negedge clk);
        Start = 1'b0;
        MDOp  = 3'($urandom);
        A     = $urandom;
        B     = $urandom;
    endtask

    // Count Busy cycles (bounded) and note whether HI/LO stayed put meanwhile.
    task automatic wait_idle(input logic [31:0] h_hi, input logic [31:0] h_lo,
                             output int n, output bit held);
        n    = 0;
        held = 1'b1;
        while (Busy !== 1'b0 && n < 200) begin
            if (HI !== h_hi || LO !== h_lo) held = 1'b0;
            n++;
            @(negedge clk);
        end
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int n, output bit held);
        logic [31:0] h_hi;
        logic [31:0] h_lo;
        h_hi = HI;
        h_lo = LO;
        model(op, a, b);
        issue(op, a, b);
        wait_idle(h_hi, h_lo, n, held);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        Start = 1'b1;
        MDOp  = 3'd4;
        A     = 32'hDEAD_BEEF;
        @(negedge clk);
        @(negedge clk);
        Start  = 1'b0;
        exp_hi = 32'd0;
        exp_lo = 32'd0;
        total += 3;
        if (HI !== exp_hi) begin bad++; $display("FAIL reset_hi: got %h exp %h", HI, exp_hi); end
        if (LO !== exp_lo) begin bad++; $display("FAIL reset_lo: got %h exp %h", LO, exp_lo); end
        if (Busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b exp 0", Busy); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_mult();
        int n; bit held;
        run_op(3'd0, 32'hFFFF_FFFE, 32'd3, n, held);
        total += 4;
        if (n != 5) begin bad++; $display("FAIL mult_busy: got %0d exp 5", n); end
        if (!held) begin bad++; $display("FAIL mult_hold: HI/LO changed during RUN"); end
        if (HI !== 32'hFFFF_FFFF) begin bad++; $display("FAIL mult_hi: got %h exp ffffffff", HI); end
        if (LO !== 32'hFFFF_FFFA) begin bad++; $display("FAIL mult_lo: got %h exp fffffffa", LO); end
    endtask

    task automatic test_multu();
        int n; bit held;
        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, n, held);
        total += 3;
        if (n != 5) begin bad++; $display("FAIL multu_busy: got %0d exp 5", n); end
        if (HI !== 32'hFFFF_FFFE) begin bad++; $display("FAIL multu_hi: got %h exp fffffffe", HI); end
        if (LO !== 32'h0000_0001) begin bad++; $display("FAIL multu_lo: got %h exp 00000001", LO); end
    endtask

    task automatic test_div();
        int n; bit held;
        run_op(3'd2, 32'hFFFF_FFF9, 32'd2, n, held);
        total += 4;
        if (n != 10) begin bad++; $display("FAIL div_busy: got %0d exp 10", n); end
        if (!held) begin bad++; $display("FAIL div_hold: HI/LO changed during RUN"); end
        if (LO !== 32'hFFFF_FFFD) begin bad++; $display("FAIL div_lo: got %h exp fffffffd", LO); end
        if (HI !== 32'hFFFF_FFFF) begin bad++; $display("FAIL div_hi: got %h exp ffffffff", HI); end
        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, n, held);
        total += 2;
        if (LO !== 32'h8000_0000) begin bad++; $display("FAIL div_ovf_lo: got %h exp 80000000", LO); end
        if (HI !== 32'h0000_0000) begin bad++; $display("FAIL div_ovf_hi: got %h exp 00000000", HI); end
    endtask

    task automatic test_div_zero();
        int n; bit held;
        run_op(3'd4, 32'h11, 32'h0, n, held);
        run_op(3'd5, 32'h22, 32'h0, n, held);
        total += 2;
        if (HI !== 32'h11) begin bad++; $display("FAIL mthi_preset: got %h exp 00000011", HI); end
        if (LO !== 32'h22) begin bad++; $display("FAIL mtlo_preset: got %h exp 00000022", LO); end
        run_op(3'd3, 32'd5, 32'd0, n, held);
        total += 3;
        if (n != 10) begin bad++; $display("FAIL divz_busy: got %0d exp 10", n); end
        if (HI !== 32'h11) begin bad++; $display("FAIL divz_hi: got %h exp 00000011", HI); end
        if (LO !== 32'h22) begin bad++; $display("FAIL divz_lo: got %h exp 00000022", LO); end
    endtask

    task automatic test_busy_ignore();
        int n; bit held;
        model(3'd0, 32'd2, 32'd3);
        issue(3'd0, 32'd2, 32'd3);
        @(negedge clk);
        Start = 1'b1; MDOp = 3'd2; A = 32'd9; B = 32'd2;
        @(negedge clk);
        Start = 1'b0;
        wait_idle(HI, LO, n, held);
        total += 3;
        if (n + 2 != 5) begin bad++; $display("FAIL ignore_busy: got %0d exp 5", n + 2); end
        if (HI !== 32'd0) begin bad++; $display("FAIL ignore_hi: got %h exp 00000000", HI); end
        if (LO !== 32'd6) begin bad++; $display("FAIL ignore_lo: got %h exp 00000006", LO); end
        @(negedge clk);
        total += 1;
        if (Busy !== 1'b0) begin bad++; $display("FAIL ignore_late: Busy got %b exp 0", Busy); end
    endtask

    task automatic test_move_nop();
        int n; bit held;
        logic [31:0] v;
        v = $urandom;
        run_op(3'd4, v, 32'd0, n, held);
        total += 3;
        if (Busy !== 1'b0) begin bad++; $display("FAIL mthi_busy: got %b exp 0", Busy); end
        if (HI !== exp_hi) begin bad++; $display("FAIL mthi_hi: got %h exp %h", HI, exp_hi); end
        if (LO !== exp_lo) begin bad++; $display("FAIL mthi_lo: got %h exp %h", LO, exp_lo); end
        v = $urandom;
        run_op(3'd5, v, 32'd0, n, held);
        total += 2;
        if (HI !== exp_hi) begin bad++; $display("FAIL mtlo_hi: got %h exp %h", HI, exp_hi); end
        if (LO !== exp_lo) begin bad++; $display("FAIL mtlo_lo: got %h exp %h", LO, exp_lo); end
        for (int k = 6; k < 8; k++) begin
            run_op(3'(k), $urandom, $urandom, n, held);
            total += 3;
            if (Busy !== 1'b0) begin bad++; $display("FAIL nop_busy: op %0d got %b exp 0", k, Busy); end
            if (HI !== exp_hi) begin bad++; $display("FAIL nop_hi: op %0d got %h exp %h", k, HI, exp_hi); end
            if (LO !== exp_lo) begin bad++; $display("FAIL nop_lo: op %0d got %h exp %h", k, LO, exp_lo); end
        end
    endtask

    task automatic test_reset_mid();
        int n; bit held;
        bit stay;
        run_op(3'd4, 32'h55, 32'd0, n, held);
        run_op(3'd5, 32'h66, 32'd0, n, held);
        issue(3'd3, 32'd100, 32'd7);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_hi = 32'd0;
        exp_lo = 32'd0;
        total += 3;
        if (HI !== 32'd0) begin bad++; $display("FAIL rmid_hi: got %h exp 00000000", HI); end
        if (LO !== 32'd0) begin bad++; $display("FAIL rmid_lo: got %h exp 00000000", LO); end
        if (Busy !== 1'b0) begin bad++; $display("FAIL rmid_busy: got %b exp 0", Busy); end
        stay = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (HI !== 32'd0 || LO !== 32'd0 || Busy !== 1'b0) stay = 1'b0;
        end
        total += 1;
        if (!stay) begin bad++; $display("FAIL rmid_stay: HI %h LO %h Busy %b exp zeros", HI, LO, Busy); end
    endtask

    task automatic test_back_to_back();
        int n; bit held;
        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, n, held);
        total += 3;
        if (n != 5) begin bad++; $display("FAIL b2b_mult_busy: got %0d exp 5", n); end
        if (HI !== exp_hi) begin bad++; $display("FAIL b2b_mult_hi: got %h exp %h", HI, exp_hi); end
        if (LO !== exp_lo) begin bad++; $display("FAIL b2b_mult_lo: got %h exp %h", LO, exp_lo); end
        run_op(3'd3, $urandom, 32'($urandom_range(1, 1000)), n, held);
        total += 3;
        if (n != 10) begin bad++; $display("FAIL b2b_div_busy: got %0d exp 10", n); end
        if (HI !== exp_hi) begin bad++; $display("FAIL b2b_div_hi: got %h exp %h", HI, exp_hi); end
        if (LO !== exp_lo) begin bad++; $display("FAIL b2b_div_lo: got %h exp %h", LO, exp_lo); end
    endtask

    task automatic test_random();
        int n; bit held;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1:       b = 32'hFFFF_FFFF;
                2:       b = 32'($urandom_range(1, 16));
                3:       b = 32'd0 - 32'($urandom_range(1, 16));
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 9) == 0) a = 32'h8000_0000;
            run_op(op, a, b, n, held);
            total += 4;
            if (n != exp_cycles(op)) begin bad++; $display("FAIL rnd_busy: op %0d got %0d exp %0d", op, n, exp_cycles(op)); end
            if (!held) begin bad++; $display("FAIL rnd_hold: op %0d HI/LO changed during RUN", op); end
            if (HI !== exp_hi) begin bad++; $display("FAIL rnd_hi: op %0d a %h b %h got %h exp %h", op, a, b, HI, exp_hi); end
            if (LO !== exp_lo) begin bad++; $display("FAIL rnd_lo: op %0d a %h b %h got %h exp %h", op, a, b, LO, exp_lo); end
        end
    endtask

    initial begin
        reset = 1'b1;
        Start = 1'b0;
        MDOp  = 3'd0;
        A     = 32'd0;
        B     = 32'd0;
        exp_hi = 32'd0;
        exp_lo = 32'd0;
        @(negedge clk);
        test_reset();
        test_mult();
        test_multu();
        test_div();
        test_div_zero();
        test_busy_ignore();
        test_move_nop();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk and reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous active-high reset, sampled on the rising edge of clk.
REQ-004 Start  input  1  one-cycle request; qualifies MDOp, A and B on the same edge.
REQ-005 MDOp  input  3  operation: 000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo, 110/111 no-op.
REQ-006 A  input  32  operand rs (dividend / multiplicand / mthi-mtlo source).
REQ-007 B  input  32  operand rt (divisor / multiplier).
REQ-008 Busy  output  1  an accepted mult/div is still in flight.
REQ-009 HI  output  32  HI register; feeds the EX-stage result selector, code 01.
REQ-010 LO  output  32  LO register; feeds the EX-stage result selector, code 10.
REQ-011 Parameters SHALL be MULT_CYCLES, default 5, the Busy length for mult/multu; and DIV_CYCLES, default 10, the Busy length for div/divu.

Function
REQ-012 Acceptance SHALL require Start=1, Busy=0 and reset=0 at a rising edge; Start while Busy=1 SHALL be ignored entirely, with no state change.
REQ-013 On acceptance of mult/multu/div/divu, the block SHALL latch A, B and MDOp internally; later changes to A and B SHALL NOT affect the result.
REQ-014 State machine SHALL be IDLE -> RUN on acceptance of mult/div, and RUN -> IDLE when the down-counter reaches 1; IDLE is the only state that accepts a request.
REQ-015 Busy SHALL be 1 for exactly MULT_CYCLES (mult/multu) or DIV_CYCLES (div/divu) consecutive cycles, starting with the cycle after the accepting edge.
REQ-016 HI and LO SHALL take the result at the same edge that deasserts Busy; HI and LO SHALL hold their previous values throughout RUN.
REQ-017 mult SHALL produce the signed 64-bit product of the latched A and B, with {HI,LO} = product.
REQ-018 multu SHALL produce the unsigned 64-bit product of the latched A and B, with {HI,LO} = product.
REQ-019 div SHALL give LO = signed quotient truncated toward zero and HI = remainder carrying the sign of the dividend.
REQ-020 divu SHALL give LO = unsigned quotient and HI = unsigned remainder.
REQ-021 For div/divu with latched B=0, Busy SHALL still run the full DIV_CYCLES, and HI and LO SHALL remain unchanged.
REQ-022 For signed div of 0x80000000 by 0xFFFFFFFF, the result SHALL be LO=0x80000000, HI=0 (no trap).
REQ-023 mthi SHALL write HI <= A at the accepting edge, with LO unchanged and Busy staying 0.
REQ-024 mtlo SHALL write LO <= A at the accepting edge, with HI unchanged and Busy staying 0.
REQ-025 MDOp 110/111 with Start=1 SHALL change no state.
REQ-026 A new request SHALL be accepted on the edge immediately after Busy falls, i.e. the first cycle in which Busy=0.
REQ-027 The block SHALL assert no stall itself; the hazard unit SHALL stall mfhi/mflo and mult/div/mthi/mtlo in D while (Start in E) or Busy.

Reset
REQ-028 When reset=1 at an edge, the block SHALL set HI=0, LO=0, Busy=0, counter=0 and state=IDLE.
REQ-029 Reset SHALL take priority over Start.
REQ-030 Reset during RUN SHALL discard the in-flight result; no later write to HI or LO SHALL occur.
REQ-031 Between the first edge and the first reset edge, output values SHALL be don't-care; verification SHALL begin checking after reset.

Verification
REQ-032 Signed mult: A=0xFFFFFFFE, B=3 -> Busy=1 for exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-033 Unsigned multu: A=0xFFFFFFFF, B=0xFFFFFFFF -> after 5 cycles, HI=0xFFFFFFFE, LO=0x00000001.
REQ-034 Signed div: A=-7 (0xFFFFFFF9), B=2 -> Busy for 10 cycles, then LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1).
REQ-035 Divide by zero: HI=0x11, LO=0x22 preset via mthi/mtlo, then divu A=5, B=0 -> Busy for 10 cycles, HI=0x11, LO=0x22 unchanged.
REQ-036 Start blocked while busy: mult 2*3 accepted, then at busy cycle 2 Start a div 9/2 -> div ignored; final HI=0, LO=6; Busy falls after 5 cycles.
REQ-037 Reset mid-operation: divu 100/7 accepted, reset asserted at busy cycle 4 -> next cycle HI=0, LO=0, Busy=0, and HI/LO remain 0 for 10 further cycles with Start=0.
